egress_skid_buffer: RTL and testbench

- Egress stage directly downstream of the per-requestor FIFOs and DWRR arbiter; consumes the granted FIFO head and presents one packet stream to the output port with a valid/ready handshake.
- Two-entry skid buffer decouples arbiter grants from output backpressure.
- Drives the arbiter `blk` input and keeps per-source delivered-packet counters for the scoreboard checks.

---
 rtl/egress_skid_buffer.sv | 94 +++++++++
 tb/tb_egress_skid_buffer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/egress_skid_buffer.sv
// egress_skid_buffer: two-entry skid buffer between the arbiter's granted FIFO head and the output port
module egress_skid_buffer #(
  parameter int NUM_REQS = 4,
  parameter int WIDTH = 128,
  parameter int CNTWID = 16,
  parameter int SRCW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQS-1:0]        gnt,
  input  logic [NUM_REQS*WIDTH-1:0]  flat_data_out,
  output logic                       blk,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [WIDTH-1:0]           out_data,
  output logic [SRCW-1:0]            out_src,
  output logic [NUM_REQS*CNTWID-1:0] flat_pkt_cnt,
  output logic                       err
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, state_d;
  logic [WIDTH-1:0] skid_data, new_data;
  logic [SRCW-1:0] skid_src, new_src;
  logic [CNTWID-1:0] cnt [NUM_REQS];
  logic any_gnt, multi, acc, xfer, ld_head, ld_skid, pop_skid;
  // descending scan so the lowest set grant bit wins when gnt is not one-hot
  always_comb begin
    new_data = '0;
    new_src = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--)
      if (gnt[i]) begin
        new_data = flat_data_out[i*WIDTH +: WIDTH];
        new_src = SRCW'(i);
      end
  end
  assign any_gnt = |gnt;
  assign multi = |(gnt & (gnt - NUM_REQS'(1)));
  assign out_vld = state != EMPTY;
  assign xfer = out_vld & out_rdy;
  assign acc = any_gnt & (state != FULL);
  always_comb begin
    state_d = state;
    ld_head = 1'b0;
    ld_skid = 1'b0;
    pop_skid = 1'b0;
    case (state)
      EMPTY: begin
        ld_head = acc;
        state_d = acc ? ONE : EMPTY;
      end
      ONE: begin
        ld_head = acc & xfer;
        ld_skid = acc & ~xfer;
        state_d = acc ? (xfer ? ONE : FULL) : (xfer ? EMPTY : ONE);
      end
      FULL: begin
        pop_skid = xfer;
        state_d = xfer ? ONE : FULL;
      end
      default: state_d = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= EMPTY;
      blk <= 1'b0;
      err <= 1'b0;
      out_data <= '0;
      out_src <= '0;
      skid_data <= '0;
      skid_src <= '0;
      for (int i = 0; i < NUM_REQS; i++) cnt[i] <= '0;
    end else begin
      state <= state_d;
      blk <= state_d == FULL;
      if (ld_head) begin
        out_data <= new_data;
        out_src <= new_src;
      end else if (pop_skid) begin
        out_data <= skid_data;
        out_src <= skid_src;
      end
      if (ld_skid) begin
        skid_data <= new_data;
        skid_src <= new_src;
      end
      if ((any_gnt & (state == FULL)) | multi) err <= 1'b1;
      if (xfer && cnt[out_src] != '1) cnt[out_src] <= cnt[out_src] + CNTWID'(1);
    end
  end
  for (genvar g = 0; g < NUM_REQS; g++) begin : g_cnt
    assign flat_pkt_cnt[g*CNTWID +: CNTWID] = cnt[g];
  end
endmodule

// File: tb/tb_egress_skid_buffer.sv
// tb_egress_skid_buffer: queue-based reference model plus directed and random stimulus
module tb_egress_skid_buffer;
  localparam int NR = 4;
  localparam int W = 128;
  localparam int CW = 2;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0] gnt;
  logic [NR*W-1:0] flat_data_out;
  logic blk, out_vld, out_rdy, err;
  logic [W-1:0] out_data;
  logic [SW-1:0] out_src;
  logic [NR*CW-1:0] flat_pkt_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [W-1:0] data;
    int src;
  } pkt_t;

  pkt_t q[$];
  int cnt_m [NR];
  logic err_m;
  logic started = 1'b0;

  egress_skid_buffer #(.NUM_REQS(NR), .WIDTH(W), .CNTWID(CW)) dut (
    .clk(clk), .rst(rst), .gnt(gnt), .flat_data_out(flat_data_out), .blk(blk),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_src(out_src),
    .flat_pkt_cnt(flat_pkt_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // drive one cycle; d lands in the lowest granted slice, other slices are random
  task automatic step(input logic r, input logic [NR-1:0] g, input logic rdy, input logic [W-1:0] d);
    logic [NR*W-1:0] fd;
    int lo;
    lo = 0;
    for (int i = 0; i < NR; i++) fd[i*W +: W] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = NR - 1; i >= 0; i--) if (g[i]) lo = i;
    if (g != '0) fd[lo*W +: W] = d;
    rst = r;
    gnt = g;
    out_rdy = rdy;
    flat_data_out = fd;
    @(negedge clk);
  endtask

  // reference model: a bounded FIFO of at most two packets, advanced once per edge
  initial begin
    logic r, rd, xf, ac;
    logic [NR-1:0] g;
    logic [NR*W-1:0] fd;
    logic [NR*CW-1:0] exp_cnt;
    pkt_t p;
    int lo;
    err_m = 1'b0;
    for (int i = 0; i < NR; i++) cnt_m[i] = 0;
    forever begin
      @(posedge clk);
      r = rst;
      g = gnt;
      rd = out_rdy;
      fd = flat_data_out;
      if (!r) begin
        q.delete();
        for (int i = 0; i < NR; i++) cnt_m[i] = 0;
        err_m = 1'b0;
        started = 1'b1;
      end else begin
        xf = (q.size() != 0) && rd;
        ac = (g != '0) && (q.size() < 2);
        if ((g != '0) && (q.size() == 2)) err_m = 1'b1;
        if ($countones(g) > 1) err_m = 1'b1;
        if (xf) begin
          p = q.pop_front();
          if (cnt_m[p.src] < (1 << CW) - 1) cnt_m[p.src]++;
        end
        if (ac) begin
          lo = 0;
          for (int i = NR - 1; i >= 0; i--) if (g[i]) lo = i;
          p.data = fd[lo*W +: W];
          p.src = lo;
          q.push_back(p);
        end
      end
      #1;
      if (started) begin
        for (int i = 0; i < NR; i++) exp_cnt[i*CW +: CW] = CW'(cnt_m[i]);
        check("out_vld", W'(out_vld), W'(q.size() != 0));
        check("blk", W'(blk), W'(q.size() == 2));
        check("err", W'(err), W'(err_m));
        check("pkt_cnt", W'(flat_pkt_cnt), W'(exp_cnt));
        if (q.size() != 0) begin
          check("out_data", out_data, q[0].data);
          check("out_src", W'(out_src), W'(q[0].src));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    gnt = '0;
    out_rdy = 1'b0;
    flat_data_out = '0;
    @(negedge clk);
    step(0, 4'b0000, 0, 0);
    step(0, 4'b0000, 0, 0);
    check("rst_vld", W'(out_vld), 0);
    check("rst_blk", W'(blk), 0);
    check("rst_err", W'(err), 0);
    check("rst_cnt", W'(flat_pkt_cnt), 0);
    check("rst_data", out_data, 0);
    check("rst_src", W'(out_src), 0);
    // single packet through an empty buffer
    step(1, 4'b0010, 1, 'hA5);
    check("t1_vld", W'(out_vld), 1);
    check("t1_data", out_data, 'hA5);
    check("t1_src", W'(out_src), 1);
    step(1, 4'b0000, 1, 0);
    check("t1_vld_off", W'(out_vld), 0);
    check("t1_cnt", W'(flat_pkt_cnt), 'h04);
    // fill to FULL under backpressure, then drain
    step(1, 4'b0001, 0, 'h11);
    check("t2_blk0", W'(blk), 0);
    step(1, 4'b0100, 0, 'h33);
    check("t2_blk1", W'(blk), 1);
    check("t2_head", out_data, 'h11);
    step(1, 4'b0000, 1, 0);
    check("t2_blk_fall", W'(blk), 0);
    check("t2_data2", out_data, 'h33);
    check("t2_src2", W'(out_src), 2);
    step(1, 4'b0000, 1, 0);
    check("t2_empty", W'(out_vld), 0);
    check("t2_cnt", W'(flat_pkt_cnt), 'h15);
    // back-to-back stream at full rate
    step(0, 4'b0000, 0, 0);
    for (int i = 0; i < NR; i++) begin
      step(1, NR'(1 << i), 1, W'('h100 + i));
      check("t3_data", out_data, W'('h100 + i));
      check("t3_src", W'(out_src), W'(i));
      check("t3_blk", W'(blk), 0);
    end
    step(1, 4'b0000, 1, 0);
    check("t3_cnt", W'(flat_pkt_cnt), 'h55);
    // grant while FULL is dropped and flags err
    step(1, 4'b0001, 0, 'h44);
    step(1, 4'b0010, 0, 'h55);
    step(1, 4'b1000, 0, 'h66);
    check("t4_err", W'(err), 1);
    check("t4_head", out_data, 'h44);
    step(1, 4'b0000, 1, 0);
    check("t4_second", out_data, 'h55);
    step(1, 4'b0000, 1, 0);
    check("t4_empty", W'(out_vld), 0);
    check("t4_err_held", W'(err), 1);
    check("t4_cnt", W'(flat_pkt_cnt), 'h5A);
    // multi-bit grant: lowest index accepted
    step(0, 4'b0000, 0, 0);
    step(1, 4'b0110, 0, 'h77);
    check("t5_err", W'(err), 1);
    check("t5_src", W'(out_src), 1);
    check("t5_data", out_data, 'h77);
    step(1, 4'b0000, 1, 0);
    check("t5_empty", W'(out_vld), 0);
    check("t5_cnt", W'(flat_pkt_cnt), 'h04);
    // reset while FULL, then resume
    step(1, 4'b0001, 0, 'h01);
    step(1, 4'b0010, 0, 'h02);
    step(0, 4'b1000, 1, 'h03);
    check("t6_vld", W'(out_vld), 0);
    check("t6_blk", W'(blk), 0);
    check("t6_cnt", W'(flat_pkt_cnt), 0);
    check("t6_err", W'(err), 0);
    step(1, 4'b0100, 0, 'h99);
    check("t6_resume", out_data, 'h99);
    check("t6_resume_src", W'(out_src), 2);
    step(1, 4'b0000, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 4'b0001, 1, W'(i));
    step(1, 4'b0000, 1, 0);
    check("t6_sat", W'(flat_pkt_cnt), 'h13);
    // randomized traffic, checked every cycle by the model
    for (int n = 0; n < 2000; n++) begin
      logic [NR-1:0] g;
      int r;
      r = int'($urandom_range(0, 99));
      g = (r < 40) ? '0 : (r < 95) ? NR'(1 << $urandom_range(0, NR - 1)) : NR'($urandom);
      if (blk && $urandom_range(0, 9) != 0) g = '0;
      step($urandom_range(0, 63) != 0, g, 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom});
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
